jtag_extest_sequencer: RTL and testbench

- Host-side JTAG master that runs one complete boundary-scan test per request over the 4-wire TAP (TMS/TDI/TDO, shared TCLK):
  1. load an instruction into the IR;
  2. shift a stimulus vector through the boundary-scan register;
  3. capture the shifted-out response.
- Sits between the test host logic and the boundary-scan-wrapped chip.
- Keeps an internal mirror of the target TAP controller state so that TMS sequencing is exact.

---
 rtl/jtag_seq_pkg.sv | 34 +++
 rtl/jtag_tap_mirror.sv | 37 +++
 rtl/jtag_extest_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_jtag_extest_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_seq_pkg.sv
// jtag_seq_pkg -- shared definitions for the JTAG EXTEST sequencer.
//   tap_state_e : TAP controller states, standard 16-state 1149.1 encoding
//   TLR_CYCLES  : TMS=1 cycles used to force Test-Logic-Reset
//   EXTEST      : EXTEST opcode for a 3-bit instruction register
//   is_shift()  : true for the two shift states
package jtag_seq_pkg;

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_e;

    localparam int         TLR_CYCLES = 5;
    localparam logic [2:0] EXTEST     = 3'b001;

    function automatic logic is_shift(input tap_state_e s);
        return (s == SH_IR) || (s == SH_DR);
    endfunction

endpackage

// File: rtl/jtag_tap_mirror.sv
// jtag_tap_mirror -- combinational TAP controller next-state function.
// Mirrors what the target TAP does at the rising TCLK edge for a given TMS.
//   state_i : current mirrored TAP state
//   tms_i   : TMS value being driven during the current cycle
//   next_o  : state the target will be in after the closing edge
module jtag_tap_mirror
    import jtag_seq_pkg::*;
(
    input  tap_state_e state_i,
    input  logic       tms_i,
    output tap_state_e next_o
);

    always_comb begin
        next_o = TLR;
        case (state_i)
            TLR:      next_o = tms_i ? TLR      : RTI;
            RTI:      next_o = tms_i ? SEL_DR   : RTI;
            SEL_DR:   next_o = tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   next_o = tms_i ? EX1_DR   : SH_DR;
            SH_DR:    next_o = tms_i ? EX1_DR   : SH_DR;
            EX1_DR:   next_o = tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_o = tms_i ? EX2_DR   : PAUSE_DR;
            EX2_DR:   next_o = tms_i ? UPD_DR   : SH_DR;
            UPD_DR:   next_o = tms_i ? SEL_DR   : RTI;
            SEL_IR:   next_o = tms_i ? TLR      : CAP_IR;
            CAP_IR:   next_o = tms_i ? EX1_IR   : SH_IR;
            SH_IR:    next_o = tms_i ? EX1_IR   : SH_IR;
            EX1_IR:   next_o = tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_o = tms_i ? EX2_IR   : PAUSE_IR;
            EX2_IR:   next_o = tms_i ? UPD_IR   : SH_IR;
            UPD_IR:   next_o = tms_i ? SEL_DR   : RTI;
            default:  next_o = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_extest_sequencer.sv
// jtag_extest_sequencer -- host-side JTAG master running one boundary-scan
// test per Start: load IR, shift Vector through the BSR, capture the response.
//   TCLK, RstBar   : test clock / async active-low reset (shared with target)
//   Start          : request, accepted only while idle in RTI
//   Instr, Vector  : instruction and stimulus, latched on acceptance
//   TDO            : serial data from target, sampled during SH_DR
//   TMS, TDI       : registered TAP drive
//   Busy, Done     : run in progress / one-cycle completion pulse
//   Response       : captured chain contents, updated with Done
// Optional build macro JTAG_SEQ_TLR_PREAMBLE_EN: each run first forces the
// target through Test-Logic-Reset (5x TMS=1, then TMS=0 back to RTI).
module jtag_extest_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int IR_W  = 3,
    parameter int BSR_W = 20,
    parameter int CNT_W = $clog2((IR_W > BSR_W) ? IR_W : BSR_W)
) (
    input  logic             TCLK,
    input  logic             RstBar,
    input  logic             Start,
    input  logic [IR_W-1:0]  Instr,
    input  logic [BSR_W-1:0] Vector,
    input  logic             TDO,
    output logic             TMS,
    output logic             TDI,
    output logic             Busy,
    output logic             Done,
    output logic [BSR_W-1:0] Response
);

    localparam logic [CNT_W-1:0] IR_LAST  = CNT_W'(IR_W - 1);
    localparam logic [CNT_W-1:0] BSR_LAST = CNT_W'(BSR_W - 1);

    // state_q is the state the target occupies during the current cycle;
    // tms_q/tdi_q are the values it consumes at this cycle's closing edge.
    tap_state_e       state_q, state_d, state_nxt;
    logic             tms_q, tms_d;
    logic             tdi_q, tdi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ir_done_q, ir_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IR_W-1:0]  instr_q, instr_d;
    logic [BSR_W-1:0] vec_q, vec_d;
    logic [BSR_W-1:0] cap_q, cap_d;
    logic [BSR_W-1:0] resp_q, resp_d;
    logic [IR_W-1:0]  ir_sh;
    logic [BSR_W-1:0] dr_sh;
    logic             accept;

`ifdef JTAG_SEQ_TLR_PREAMBLE_EN
    localparam int PRE_W = $clog2(TLR_CYCLES + 2);
    logic             pre_q, pre_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
`endif

    jtag_tap_mirror u_mirror (
        .state_i (state_q),
        .tms_i   (tms_q),
        .next_o  (state_nxt)
    );

    // Idle is RTI with no run in flight; the Done cycle qualifies too,
    // which is what lets a held Start run tests back to back.
    assign accept = Start && (state_q == RTI) && !busy_q;

    always_comb begin
        state_d   = state_nxt;
        tms_d     = 1'b1;
        tdi_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ir_done_d = ir_done_q;
        cnt_d     = '0;
        instr_d   = instr_q;
        vec_d     = vec_q;
        cap_d     = cap_q;
        resp_d    = resp_q;
        ir_sh     = '0;
        dr_sh     = '0;

        // TDO is only meaningful while the target shifts its BSR.
        if (state_q == SH_DR)
            cap_d = (cap_q & ~(BSR_W'(1) << cnt_q)) | (BSR_W'(TDO) << cnt_q);

        if (state_q == UPD_IR)
            ir_done_d = 1'b1;

        if ((state_q == UPD_DR) && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            resp_d = cap_q;
        end

        if (accept) begin
            instr_d   = Instr;
            vec_d     = Vector;
            busy_d    = 1'b1;
            ir_done_d = 1'b0;
        end

        // Bit index of the shift cycle being entered; zero everywhere else.
        if (is_shift(state_d))
            cnt_d = (state_q == state_d) ? cnt_q + CNT_W'(1) : '0;

        // TMS for the cycle about to start, chosen by the state entered.
        case (state_d)
            TLR:     tms_d = 1'b0;
            RTI:     tms_d = busy_d;        // leave RTI only while a run is active
            SEL_DR:  tms_d = !ir_done_d;    // IR first, then the DR pass
            SEL_IR:  tms_d = 1'b0;
            CAP_IR:  tms_d = 1'b0;
            CAP_DR:  tms_d = 1'b0;
            SH_IR:   tms_d = (cnt_d == IR_LAST);
            SH_DR:   tms_d = (cnt_d == BSR_LAST);
            EX1_IR:  tms_d = 1'b1;
            EX1_DR:  tms_d = 1'b1;
            UPD_IR:  tms_d = 1'b0;
            UPD_DR:  tms_d = 1'b0;
            default: tms_d = 1'b1;          // unreachable; steer toward TLR
        endcase

        if (state_d == SH_IR) begin
            ir_sh = instr_q >> cnt_d;
            tdi_d = ir_sh[0];
        end else if (state_d == SH_DR) begin
            dr_sh = vec_q >> cnt_d;
            tdi_d = dr_sh[0];
        end

`ifdef JTAG_SEQ_TLR_PREAMBLE_EN
        // pre_cnt counts TMS cycles already committed in the preamble:
        // 1..TLR_CYCLES are TMS=1, the next one is TMS=0 (TLR -> RTI), after
        // which the normal sequence starts from RTI as if just accepted.
        pre_d     = pre_q;
        pre_cnt_d = pre_cnt_q;
        if (accept) begin
            pre_d     = 1'b1;
            pre_cnt_d = PRE_W'(1);
            tms_d     = 1'b1;
        end else if (pre_q) begin
            tdi_d = 1'b0;
            cnt_d = '0;
            if (pre_cnt_q < PRE_W'(TLR_CYCLES)) begin
                tms_d     = 1'b1;
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end else if (pre_cnt_q == PRE_W'(TLR_CYCLES)) begin
                tms_d     = 1'b0;
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end else begin
                pre_d     = 1'b0;
                pre_cnt_d = '0;
                tms_d     = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            state_q   <= TLR;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ir_done_q <= 1'b0;
            cnt_q     <= '0;
            instr_q   <= IR_W'(EXTEST);
            vec_q     <= '0;
            cap_q     <= '0;
            resp_q    <= '0;
`ifdef JTAG_SEQ_TLR_PREAMBLE_EN
            pre_q     <= 1'b0;
            pre_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ir_done_q <= ir_done_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            vec_q     <= vec_d;
            cap_q     <= cap_d;
            resp_q    <= resp_d;
`ifdef JTAG_SEQ_TLR_PREAMBLE_EN
            pre_q     <= pre_d;
            pre_cnt_q <= pre_cnt_d;
`endif
        end
    end

    assign TMS      = tms_q;
    assign TDI      = tdi_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Response = resp_q;

endmodule

// File: tb/tb_jtag_extest_sequencer.sv
module tb_jtag_extest_sequencer;

`ifdef JTAG_SEQ_TLR_PREAMBLE_EN
    localparam int PRE = 6;
`else
    localparam int PRE = 0;
`endif
    localparam int IRW = 3;
    localparam int BSW = 20;
    localparam int LAT = 11 + IRW + BSW + PRE;

    logic            TCLK = 1'b0;
    logic            RstBar, Start, TDO = 1'b0;
    logic [IRW-1:0]  Instr;
    logic [BSW-1:0]  Vector, Response;
    logic            TMS, TDI, Busy, Done;

    jtag_extest_sequencer #(.IR_W(IRW), .BSR_W(BSW)) dut (
        .TCLK(TCLK), .RstBar(RstBar), .Start(Start), .Instr(Instr),
        .Vector(Vector), .TDO(TDO), .TMS(TMS), .TDI(TDI), .Busy(Busy),
        .Done(Done), .Response(Response)
    );

    always #5 TCLK = ~TCLK;

    // ---------------- ideal target: TAP + 3-bit IR + 20-bit chain ----------
    typedef enum int {T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR,
                      T_UDR, T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tst_t;

    function automatic tst_t tnext(input tst_t s, input logic m);
        case (s)
            T_TLR:  return m ? T_TLR  : T_RTI;
            T_RTI:  return m ? T_SDR  : T_RTI;
            T_SDR:  return m ? T_SIR  : T_CDR;
            T_CDR:  return m ? T_E1DR : T_SHDR;
            T_SHDR: return m ? T_E1DR : T_SHDR;
            T_E1DR: return m ? T_UDR  : T_PDR;
            T_PDR:  return m ? T_E2DR : T_PDR;
            T_E2DR: return m ? T_UDR  : T_SHDR;
            T_UDR:  return m ? T_SDR  : T_RTI;
            T_SIR:  return m ? T_TLR  : T_CIR;
            T_CIR:  return m ? T_E1IR : T_SHIR;
            T_SHIR: return m ? T_E1IR : T_SHIR;
            T_E1IR: return m ? T_UIR  : T_PIR;
            T_PIR:  return m ? T_E2IR : T_PIR;
            T_E2IR: return m ? T_UIR  : T_SHIR;
            default: return m ? T_SDR : T_RTI;   // T_UIR
        endcase
    endfunction

    tst_t           t_st = T_TLR;
    logic [IRW-1:0] t_irsh = '0, t_ir = '0;
    logic [BSW-1:0] t_chain = '0, t_upd = '0, ld_val = '0;
    int             ld_seq = 0, ld_seen = 0;

    always @(posedge TCLK or negedge RstBar) begin
        if (!RstBar) t_st <= T_TLR;
        else begin
            t_st <= tnext(t_st, TMS);
            case (t_st)
                T_CIR:  t_irsh  <= 3'b001;
                T_SHIR: t_irsh  <= {TDI, t_irsh[IRW-1:1]};
                T_UIR:  t_ir    <= t_irsh;
                T_SHDR: t_chain <= {TDI, t_chain[BSW-1:1]};
                T_UDR:  t_upd   <= t_chain;
                default: ;
            endcase
            if (ld_seq != ld_seen) begin
                t_chain <= ld_val;
                ld_seen <= ld_seq;
            end
        end
    end

    // TDO valid from the falling edge; garbage outside SH_DR must be ignored.
    always @(negedge TCLK)
        TDO <= (t_st == T_SHDR) ? t_chain[0] : 1'($urandom_range(0, 1));

    // ---------------- checking ----------------------------------------------
    int n_vec = 0, n_err = 0;
    bit exp_tms[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // TMS sequence after each edge 0..LAT-1, built from the transition list.
    function automatic void build_tms();
        exp_tms = {};
        if (PRE != 0) begin
            repeat (5) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
        end
        exp_tms.push_back(1); exp_tms.push_back(1); exp_tms.push_back(0); exp_tms.push_back(0);
        for (int i = 0; i < IRW; i++) exp_tms.push_back(i == IRW - 1);
        exp_tms.push_back(1); exp_tms.push_back(0);
        exp_tms.push_back(1); exp_tms.push_back(0); exp_tms.push_back(0);
        for (int i = 0; i < BSW; i++) exp_tms.push_back(i == BSW - 1);
        exp_tms.push_back(1); exp_tms.push_back(0);
    endfunction

    // Called at a negedge with the DUT idle; returns one cycle after Done.
    task automatic run_one(input logic [IRW-1:0] ins, input logic [BSW-1:0] vec,
                           input logic [BSW-1:0] pre, input logic [BSW-1:0] er,
                           input logic [IRW-1:0] ei, input logic [BSW-1:0] ec,
                           input int glitch_e, input string nm);
        int tms_bad = 0, busy_bad = 0, done_bad = 0, hold_bad = 0;
        logic [BSW-1:0] hold;
        ld_val = pre; ld_seq++;
        Instr = ins; Vector = vec; Start = 1'b1;
        @(posedge TCLK);
        @(negedge TCLK);
        Start = 1'b0; Instr = IRW'($urandom); Vector = BSW'($urandom);
        hold = Response;
        for (int e = 0; e < LAT; e++) begin
            if (TMS !== exp_tms[e]) tms_bad++;
            if (Busy !== 1'b1) busy_bad++;
            if (Done !== 1'b0) done_bad++;
            if (Response !== hold) hold_bad++;
            if (e == glitch_e - 1) Start = 1'b1;
            if (e == glitch_e) Start = 1'b0;
            @(negedge TCLK);
        end
        chk({nm, " tms_trace_errs"}, tms_bad, 0);
        chk({nm, " busy_errs"}, busy_bad, 0);
        chk({nm, " early_done"}, done_bad + hold_bad, 0);
        chk({nm, " done"}, Done, 1);
        chk({nm, " busy_end"}, Busy, 0);
        chk({nm, " response"}, Response, er);
        chk({nm, " target_ir"}, t_ir, ei);
        chk({nm, " target_chain"}, t_upd, ec);
        @(negedge TCLK);
        chk({nm, " done_pulse"}, Done, 0);
    endtask

    typedef struct {
        logic [IRW-1:0] instr;
        logic [BSW-1:0] vec;
        logic [BSW-1:0] preload;
        logic [BSW-1:0] exp_resp;
        logic [IRW-1:0] exp_ir;
        logic [BSW-1:0] exp_chain;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [IRW-1:0] ri;
        logic [BSW-1:0] rv, rp, v1, v2, p0;
        int cnt, bad;

        tbl[0] = '{3'b001, 20'hA5A5A, 20'h0F0F0, 20'h0F0F0, 3'b001, 20'hA5A5A};
        tbl[1] = '{3'b111, 20'hFFFFF, 20'h00000, 20'h00000, 3'b111, 20'hFFFFF};
        tbl[2] = '{3'b000, 20'h00000, 20'hFFFFF, 20'hFFFFF, 3'b000, 20'h00000};
        tbl[3] = '{3'b100, 20'h80001, 20'h7FFFE, 20'h7FFFE, 3'b100, 20'h80001};
        tbl[4] = '{3'b010, 20'h12345, 20'h6789A, 20'h6789A, 3'b010, 20'h12345};
        build_tms();

        // ---- reset then idle ----
        RstBar = 1'b0; Start = 1'b0; Instr = '0; Vector = '0;
        repeat (3) @(negedge TCLK);
        chk("rst tms", TMS, 1); chk("rst busy", Busy, 0);
        chk("rst done", Done, 0); chk("rst resp", Response, 0); chk("rst tdi", TDI, 0);
        RstBar = 1'b1;
        #1 chk("post-rst tms first cycle", TMS, 1);
        @(negedge TCLK);
        bad = 0;
        repeat (4) begin
            if (TMS !== 1'b0 || TDI !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) bad++;
            @(negedge TCLK);
        end
        chk("idle steady", bad, 0);

        // ---- table-driven runs ----
        for (int i = 0; i < 5; i++)
            run_one(tbl[i].instr, tbl[i].vec, tbl[i].preload, tbl[i].exp_resp,
                    tbl[i].exp_ir, tbl[i].exp_chain, -5, $sformatf("tbl%0d", i));

        // ---- randomized runs: a full-length shift swaps chain contents ----
        for (int i = 0; i < 6; i++) begin
            ri = IRW'($urandom); rv = BSW'($urandom); rp = BSW'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge TCLK);
            run_one(ri, rv, rp, rp, ri, rv, -5, $sformatf("rnd%0d", i));
        end

        // ---- Start while Busy is ignored ----
        run_one(3'b001, 20'h3C3C3, 20'h55AA5, 20'h55AA5, 3'b001, 20'h3C3C3, 10, "glitch");
        cnt = 0;
        repeat (LAT + 5) begin
            if (Done === 1'b1 || Busy === 1'b1) cnt++;
            @(negedge TCLK);
        end
        chk("glitch no second run", cnt, 0);

        // ---- back-to-back with Start held ----
        v1 = 20'hC0FFE; v2 = 20'h1BEEF; p0 = 20'h13579;
        ld_val = p0; ld_seq++;
        Instr = 3'b001; Vector = v1; Start = 1'b1;
        @(posedge TCLK);
        @(negedge TCLK);
        Vector = v2;
        bad = 0;
        for (int e = 0; e <= 2 * LAT + 1; e++) begin
            if (Done !== ((e == LAT) || (e == 2 * LAT + 1))) bad++;
            if (Busy !== ((e < LAT) || (e >= LAT + 1 && e < 2 * LAT + 1))) bad++;
            if (e == LAT) chk("b2b resp1", Response, p0);
            if (e == 2 * LAT + 1) chk("b2b resp2", Response, v1);
            if (e == LAT + 1) Start = 1'b0;
            @(negedge TCLK);
        end
        chk("b2b done/busy pattern errs", bad, 0);
        chk("b2b tail done", Done, 0);
        chk("b2b chain", t_upd, v2);

        // ---- reset during SH_DR bit 7 ----
        ld_val = 20'h0AAAA; ld_seq++;
        Instr = 3'b001; Vector = 20'hF00F0; Start = 1'b1;
        @(posedge TCLK);
        @(negedge TCLK);
        Start = 1'b0;
        repeat (PRE + 19) @(negedge TCLK);
        chk("pre-reset in SH_DR", (t_st == T_SHDR) ? 1 : 0, 1);
        RstBar = 1'b0;
        #1;
        chk("midrst tms", TMS, 1); chk("midrst busy", Busy, 0);
        chk("midrst done", Done, 0); chk("midrst resp", Response, 0);
        @(negedge TCLK);
        RstBar = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge TCLK);
            if (Done === 1'b1 || Busy === 1'b1) cnt++;
        end
        chk("midrst no done", cnt, 0);
        run_one(3'b001, 20'hA5A5A, 20'h0F0F0, 20'h0F0F0, 3'b001, 20'hA5A5A, -5, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
